decoder_scan_nx2n: RTL and testbench
====================================

Name: decoder_scan_nx2n

Overview:
- Parametrised, registered N-to-2^N one-hot decoder; successor to the fixed 4x16 combinational decoder.
- Two modes:
  - Direct: decode a loaded code.
  - Scan: autonomously walk every code 0..2^N-1 with a programmable dwell time, using a start/busy/done handshake.
- Drives register-file write-enables and bench/lab sweep sequences from a single block.

Parameters:
- N, 4, select width; output width is 2^N (legal range 1..6).
- DW, 4, dwell-count width; each scanned code is held DWELL+1 cycles.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous reset, active-high.
- MODE  in  1  0 = direct, 1 = scan; sampled only in IDLE.
- I  in  N  code to decode in direct mode.
- LOAD  in  1  direct-mode strobe; honoured only in IDLE with MODE=0.
- START  in  1  scan-mode strobe; honoured only in IDLE with MODE=1.
- ABORT  in  1  terminates a scan.
- EN  in  1  output enable; 0 forces the D register to the inactive value.
- DWELL  in  DW  per-code hold count minus one; sampled at START.
- D  out  2^N  registered one-hot select.
- CODE  out  N  registered code currently represented in D.
- BUSY  out  1  high while in SCAN.
- DONE  out  1  one-cycle pulse when a scan completes normally.

Behaviour:
- Reset (RST=1 at a rising edge, any state, including mid-scan):
  - D=0, CODE=0, BUSY=0, DONE=0; state=IDLE.
  - Dwell counter and latched dwell are cleared.
- States: IDLE, SCAN, FIN.
- IDLE, direct mode:
  - LOAD=1 and MODE=0 → next edge: CODE=I; D=EN ? (1<<I) : 0.
  - Latency 1 cycle. D and CODE hold until the next LOAD, EN change, or START.
- EN in IDLE:
  - EN 1→0: D becomes 0 at the next edge; CODE is held.
  - EN 0→1 without LOAD: D becomes 1<<CODE at the next edge.
  - EN applies in every state; CODE and the scan sequence advance regardless of EN.
- IDLE, scan mode:
  - START=1 and MODE=1 → SCAN.
  - At that edge: CODE=0, D=1 (if EN), BUSY=1; latch DWELL into a DW-bit dwell register; dwell counter=0.
- SCAN:
  - Dwell counter increments each cycle.
  - When counter equals the latched dwell and CODE != all-ones: CODE+1, D shifts left by one, counter=0.
  - Result: each code is visible for exactly DWELL+1 cycles. DWELL=0 advances every cycle.
- SCAN terminal: when counter equals the latched dwell and CODE is all-ones → FIN.
  - At that edge: D=0, BUSY=0, DONE=1, CODE held at all-ones.
  - CODE never wraps to 0 inside a scan.
- FIN:
  - Lasts exactly one cycle; DONE=1 only here.
  - → IDLE with DONE=0.
  - LOAD/START during FIN are ignored.
- ABORT:
  - In SCAN: next edge → IDLE with D=0, BUSY=0, DONE=0, CODE held at its current value.
  - In IDLE or FIN: ignored.
  - ABORT has priority over a terminal advance in the same cycle.
- BUSY=1 (SCAN): LOAD and START are ignored; DWELL and MODE changes have no effect.
- Simultaneous LOAD and START in IDLE: MODE selects which one is honoured; the other is dropped.
- Width rules:
  - D is exactly 2^N bits.
  - At most one bit of D is high at every edge.
  - CODE arithmetic is N-bit unsigned.
  - The dwell comparison is DW-bit unsigned equality.

Optional Feature:
- Macro: DECODER_ACTIVE_LOW_EN.
- Defined:
  - D is driven inverted: one-cold selects, 74x154 style.
  - Reset, EN=0, ABORT and FIN values of D become all-ones; the selected bit is 0.
  - All other outputs are unchanged.
- Undefined: active-high one-hot as described above.

Decomposition:
- Package decoder_scan_pkg:
  - State enum (IDLE, SCAN, FIN).
  - MODE_DIRECT=0 and MODE_SCAN=1 constants.
  - Function computing the output width 2^N.
- Sub-module: decoder_nx2n, a purely combinational N→2^N one-hot decoder (parameter N).
  - Instantiated once.
  - Its output is registered, and polarity-adjusted under the macro, in the top level.

Test Plan:
- Reset, then direct LOAD with I=0..15 (N=4, EN=1) → one cycle after each LOAD, D=16'h0001<<I and CODE=I. Assert RST mid-sequence → next edge D=0, CODE=0.
- Direct LOAD I=9, then EN=0 for 3 cycles, then EN=1 → D=16'h0200, then 16'h0000 (CODE stays 9), then 16'h0200.
- START with MODE=1, DWELL=0 → BUSY=1 for 16 cycles.
  - D steps 0001, 0002, …, 8000 one per cycle.
  - Then DONE=1 for exactly one cycle with D=0 and CODE=15; then IDLE.
- START with DWELL=2 → each code held exactly 3 cycles; scan lasts 48 cycles. LOAD and START pulsed mid-scan are ignored.
- START with DWELL=1, ABORT when CODE=5 → next edge D=0, BUSY=0, DONE never asserted, CODE=5.
- Rebuild with DECODER_ACTIVE_LOW_EN and N=2:
  - Reset gives D=4'b1111.
  - LOAD I=2 gives D=4'b1011.
  - EN=0 gives D=4'b1111.

Source files
------------

// File: rtl/decoder_scan_pkg.sv
// Shared types and helpers for the scanning N-to-2^N decoder.
package decoder_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  function automatic int out_width(input int n);
    return 32'sd1 << n;
  endfunction

endpackage

// File: rtl/decoder_nx2n.sv
// Purely combinational N-to-2^N one-hot decoder.
module decoder_nx2n
  import decoder_scan_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]            sel,
  output logic [out_width(N)-1:0] onehot
);

  // Single bit set at the position given by sel.
  always_comb begin
    onehot      = '0;
    onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/decoder_scan_nx2n.sv
// Registered N-to-2^N decoder with direct-load and autonomous scan modes.
// Define DECODER_ACTIVE_LOW_EN to drive D one-cold (inactive value all-ones).
module decoder_scan_nx2n
  import decoder_scan_pkg::*;
#(
  parameter int N  = 4,
  parameter int DW = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    MODE,
  input  logic [N-1:0]            I,
  input  logic                    LOAD,
  input  logic                    START,
  input  logic                    ABORT,
  input  logic                    EN,
  input  logic [DW-1:0]           DWELL,
  output logic [out_width(N)-1:0] D,
  output logic [N-1:0]            CODE,
  output logic                    BUSY,
  output logic                    DONE
);

  localparam int W = out_width(N);
  localparam logic [N-1:0] CODE_MAX = {N{1'b1}};
`ifdef DECODER_ACTIVE_LOW_EN
  localparam logic [W-1:0] D_OFF = {W{1'b1}};
`else
  localparam logic [W-1:0] D_OFF = {W{1'b0}};
`endif

  state_t         state_r;
  logic [N-1:0]   code_r;
  logic [N-1:0]   code_nxt_s;
  logic [W-1:0]   dec_s;
  logic [W-1:0]   d_r;
  logic [DW-1:0]  dwell_r;
  logic [DW-1:0]  cnt_r;
  logic           busy_r;
  logic           done_r;
  logic           shown_r;
  logic           en_q_r;
  logic           shown_nxt_s;
  logic           dwell_hit_s;

  function automatic logic [W-1:0] drive_d(input logic on, input logic [W-1:0] sel);
`ifdef DECODER_ACTIVE_LOW_EN
    return on ? ~sel : D_OFF;
`else
    return on ? sel : D_OFF;
`endif
  endfunction

  assign dwell_hit_s = (cnt_r == dwell_r);
  // A rising EN in IDLE re-exposes the held code even without a LOAD.
  assign shown_nxt_s = shown_r | (EN & ~en_q_r);

  // Code that will be held after the coming edge; fed to the decoder.
  always_comb begin
    code_nxt_s = code_r;
    case (state_r)
      ST_IDLE: begin
        if (LOAD && (MODE == MODE_DIRECT)) begin
          code_nxt_s = I;
        end else if (START && (MODE == MODE_SCAN)) begin
          code_nxt_s = {N{1'b0}};
        end else begin
          code_nxt_s = code_r;
        end
      end
      ST_SCAN: begin
        if (!ABORT && dwell_hit_s && (code_r != CODE_MAX)) begin
          code_nxt_s = code_r + N'(1);
        end else begin
          code_nxt_s = code_r;
        end
      end
      default: code_nxt_s = code_r;
    endcase
  end

  decoder_nx2n #(.N(N)) u_dec (
    .sel    (code_nxt_s),
    .onehot (dec_s)
  );

  // Control FSM with all outputs registered.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= ST_IDLE;
      code_r  <= {N{1'b0}};
      d_r     <= D_OFF;
      dwell_r <= {DW{1'b0}};
      cnt_r   <= {DW{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      shown_r <= 1'b0;
      en_q_r  <= 1'b1;
    end else begin
      en_q_r <= EN;
      code_r <= code_nxt_s;
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (LOAD && (MODE == MODE_DIRECT)) begin
            shown_r <= 1'b1;
            d_r     <= drive_d(EN, dec_s);
          end else if (START && (MODE == MODE_SCAN)) begin
            state_r <= ST_SCAN;
            busy_r  <= 1'b1;
            dwell_r <= DWELL;
            cnt_r   <= {DW{1'b0}};
            shown_r <= 1'b1;
            d_r     <= drive_d(EN, dec_s);
          end else begin
            shown_r <= shown_nxt_s;
            d_r     <= drive_d(EN & shown_nxt_s, dec_s);
          end
        end
        ST_SCAN: begin
          if (ABORT) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            cnt_r   <= {DW{1'b0}};
            shown_r <= 1'b0;
            d_r     <= D_OFF;
          end else if (dwell_hit_s && (code_r == CODE_MAX)) begin
            state_r <= ST_FIN;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            cnt_r   <= {DW{1'b0}};
            shown_r <= 1'b0;
            d_r     <= D_OFF;
          end else if (dwell_hit_s) begin
            cnt_r <= {DW{1'b0}};
            d_r   <= drive_d(EN, dec_s);
          end else begin
            cnt_r <= cnt_r + DW'(1);
            d_r   <= drive_d(EN, dec_s);
          end
        end
        ST_FIN: begin
          state_r <= ST_IDLE;
          done_r  <= 1'b0;
          d_r     <= D_OFF;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          shown_r <= 1'b0;
          d_r     <= D_OFF;
        end
      endcase
    end
  end

  assign D    = d_r;
  assign CODE = code_r;
  assign BUSY = busy_r;
  assign DONE = done_r;

endmodule

// File: tb/tb_decoder_scan_nx2n.sv
// Self-checking bench for decoder_scan_nx2n (N=4, DW=4), polarity-aware.
module tb_decoder_scan_nx2n;

  logic        CLK = 1'b0;
  logic        RST, MODE, LOAD, START, ABORT, EN;
  logic [3:0]  I, DWELL;
  logic [15:0] D;
  logic [3:0]  CODE;
  logic        BUSY, DONE;

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  code;
    logic        busy;
    logic        done;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic [3:0]  i;
    logic        en;
    logic        start;
    logic [15:0] exp_d;
  } vec_t;
  vec_t vecs[0:19];

  decoder_scan_nx2n #(.N(4), .DW(4)) dut (
    .CLK(CLK), .RST(RST), .MODE(MODE), .I(I), .LOAD(LOAD), .START(START),
    .ABORT(ABORT), .EN(EN), .DWELL(DWELL), .D(D), .CODE(CODE), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  function automatic logic [15:0] pol(input logic [15:0] x);
`ifdef DECODER_ACTIVE_LOW_EN
    return ~x;
`else
    return x;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_next(input logic [15:0] d, input logic [3:0] code,
                             input logic busy, input logic done);
    exp_t e;
    e.d = d; e.code = code; e.busy = busy; e.done = done;
    sb_q.push_back(e);
  endtask

  task automatic step(input string name);
    exp_t e;
    @(posedge CLK);
    #1;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fails++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb_q.pop_front();
      check({name, ".D"},    {16'd0, D},    {16'd0, e.d});
      check({name, ".CODE"}, {28'd0, CODE}, {28'd0, e.code});
      check({name, ".BUSY"}, {31'd0, BUSY}, {31'd0, e.busy});
      check({name, ".DONE"}, {31'd0, DONE}, {31'd0, e.done});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 16; k++) begin
      vecs[k] = '{4'(k), 1'b1, 1'b0, pol(16'h0001 << k)};
    end
    vecs[16] = '{4'd9,  1'b0, 1'b0, pol(16'h0000)};
    vecs[17] = '{4'd3,  1'b1, 1'b0, pol(16'h0008)};
    vecs[18] = '{4'd7,  1'b1, 1'b1, pol(16'h0080)};
    vecs[19] = '{4'd15, 1'b1, 1'b1, pol(16'h8000)};

    RST = 1'b1; MODE = 1'b0; LOAD = 1'b0; START = 1'b0; ABORT = 1'b0;
    EN = 1'b1; I = 4'd0; DWELL = 4'd0;
    #1;

    expect_next(pol(16'h0000), 4'd0, 1'b0, 1'b0);
    step("reset");
    RST = 1'b0;
    expect_next(pol(16'h0000), 4'd0, 1'b0, 1'b0);
    step("idle_after_reset");

    // Direct loads; LOAD wins over START when MODE selects direct.
    for (int k = 0; k < 20; k++) begin
      I = vecs[k].i; EN = vecs[k].en; START = vecs[k].start;
      LOAD = 1'b1; MODE = 1'b0;
      expect_next(vecs[k].exp_d, vecs[k].i, 1'b0, 1'b0);
      step("direct");
      LOAD = 1'b0; START = 1'b0;
    end
    RST = 1'b1;
    expect_next(pol(16'h0000), 4'd0, 1'b0, 1'b0);
    step("reset_mid");
    RST = 1'b0;

    // EN gating of a held code.
    I = 4'd9; LOAD = 1'b1; EN = 1'b1;
    expect_next(pol(16'h0200), 4'd9, 1'b0, 1'b0);
    step("en_load9");
    LOAD = 1'b0; EN = 1'b0;
    for (int k = 0; k < 3; k++) begin
      expect_next(pol(16'h0000), 4'd9, 1'b0, 1'b0);
      step("en_off");
    end
    EN = 1'b1;
    expect_next(pol(16'h0200), 4'd9, 1'b0, 1'b0);
    step("en_on");

    // Scan, DWELL=0: one code per cycle, DWELL changes mid-scan ignored.
    MODE = 1'b1; START = 1'b1; DWELL = 4'd0;
    expect_next(pol(16'h0001), 4'd0, 1'b1, 1'b0);
    step("scan0");
    START = 1'b0; DWELL = 4'd7;
    for (int k = 1; k < 16; k++) begin
      expect_next(pol(16'h0001 << k), 4'(k), 1'b1, 1'b0);
      step("scan0");
    end
    expect_next(pol(16'h0000), 4'd15, 1'b0, 1'b1);
    step("scan0_fin");
    expect_next(pol(16'h0000), 4'd15, 1'b0, 1'b0);
    step("scan0_idle");

    // Scan, DWELL=2, with ignored LOAD/START/DWELL activity mid-scan.
    for (int t = 0; t < 48; t++) begin
      LOAD  = (t == 10);
      START = (t == 0) || (t == 20);
      MODE  = (t == 10) ? 1'b0 : 1'b1;
      I     = 4'd12;
      DWELL = (t == 0) ? 4'd2 : 4'd0;
      expect_next(pol(16'h0001 << (t / 3)), 4'(t / 3), 1'b1, 1'b0);
      step("scan2");
    end
    LOAD = 1'b0; START = 1'b0; MODE = 1'b1;
    expect_next(pol(16'h0000), 4'd15, 1'b0, 1'b1);
    step("scan2_fin");
    START = 1'b1; LOAD = 1'b1;
    expect_next(pol(16'h0000), 4'd15, 1'b0, 1'b0);
    step("fin_ignores_strobes");
    START = 1'b0; LOAD = 1'b0;

    // Scan, DWELL=1, abort while CODE=5.
    START = 1'b1; DWELL = 4'd1;
    for (int t = 0; t < 11; t++) begin
      expect_next(pol(16'h0001 << (t / 2)), 4'(t / 2), 1'b1, 1'b0);
      step("scan1");
      START = 1'b0;
    end
    ABORT = 1'b1;
    expect_next(pol(16'h0000), 4'd5, 1'b0, 1'b0);
    step("abort5");
    ABORT = 1'b0;
    for (int k = 0; k < 3; k++) begin
      expect_next(pol(16'h0000), 4'd5, 1'b0, 1'b0);
      step("abort5_hold");
    end

    // Abort beats terminal advance; EN=0 mid-scan blanks D but code advances.
    START = 1'b1; DWELL = 4'd0;
    for (int t = 0; t < 16; t++) begin
      EN = !(t >= 4 && t <= 6);
      expect_next((t >= 4 && t <= 6) ? pol(16'h0000) : pol(16'h0001 << t),
                  4'(t), 1'b1, 1'b0);
      step("scan_en");
      START = 1'b0;
    end
    EN = 1'b1; ABORT = 1'b1;
    expect_next(pol(16'h0000), 4'd15, 1'b0, 1'b0);
    step("abort_terminal");
    MODE = 1'b0; LOAD = 1'b1; I = 4'd2;
    expect_next(pol(16'h0004), 4'd2, 1'b0, 1'b0);
    step("abort_idle_ignored");
    LOAD = 1'b0; ABORT = 1'b0;

    if (sb_q.size() != 0) begin
      n_checks++;
      n_fails++;
      $display("FAIL scoreboard_drain: %0d left expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
